cnu_sched: RTL

//  Iteration/row scheduler for the shared check-node unit. Streams check-row addresses to the
//  q-message memory and tracks each row through the free-running CNU pipeline, which has no valid

---
 rtl/cnu_sched.sv | 102 ++++++++++
 1 files changed

// File: rtl/cnu_sched.sv
// Row/iteration scheduler for the shared check-node unit: issues q-message reads,
// tracks each row through the free-running CNU and strobes the matching r-message write.
module cnu_sched #(
    parameter int ROWS     = 16,
    parameter int ADDR_W   = 4,
    parameter int RD_LAT   = 1,
    parameter int PPL_LAT  = 3,
    parameter int MAX_ITER = 8,
    parameter int ITER_W   = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic              stall_i,
    input  logic              parity_ok_i,
    output logic              rd_en_o,
    output logic [ADDR_W-1:0] rd_addr_o,
    output logic              wr_en_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              converged_o,
    output logic [ITER_W-1:0] iter_cnt_o
);

    localparam int LAT = RD_LAT + PPL_LAT;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;

    state_e                      state_q;
    logic [ADDR_W-1:0]           row_q;
    logic [ITER_W-1:0]           iter_q;
    logic                        conv_q;
    logic [LAT:1]                vld_pipe_q;
    logic [LAT:1][ADDR_W-1:0]    addr_pipe_q;

    // The issue strobe follows stall in the same cycle; the row register doubles as rd_addr
    // so the address naturally holds while nothing is issued.
    assign rd_en_o     = (state_q == ISSUE) && !stall_i;
    assign rd_addr_o   = row_q;
    assign wr_en_o     = vld_pipe_q[LAT];
    assign wr_addr_o   = addr_pipe_q[LAT];
    assign busy_o      = (state_q != IDLE);
    assign done_o      = (state_q == DONE);
    assign converged_o = conv_q;
    assign iter_cnt_o  = iter_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            row_q   <= '0;
            iter_q  <= '0;
            conv_q  <= 1'b0;
        end else if (abort_i) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE: if (start_i) begin
                    state_q <= ISSUE;
                    row_q   <= '0;
                    iter_q  <= '0;
                    conv_q  <= 1'b0;
                end
                ISSUE: if (rd_en_o) begin
                    if (row_q == ADDR_W'(ROWS - 1)) state_q <= DRAIN;
                    else                            row_q   <= row_q + ADDR_W'(1);
                end
                DRAIN: if (vld_pipe_q == '0) begin
                    if (parity_ok_i) begin
                        state_q <= DONE;
                        conv_q  <= 1'b1;
                    end else if (iter_q == ITER_W'(MAX_ITER - 1)) begin
                        state_q <= DONE;
                        conv_q  <= 1'b0;
                    end else begin
                        state_q <= ISSUE;
                        iter_q  <= iter_q + ITER_W'(1);
                        row_q   <= '0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Shifts unconditionally: the CNU has no valid, so this pipe is its only notion of one.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_pipe_q  <= '0;
            addr_pipe_q <= '0;
        end else begin
            vld_pipe_q[1]  <= rd_en_o && !abort_i;
            addr_pipe_q[1] <= rd_addr_o;
            for (int i = 2; i <= LAT; i++) begin
                vld_pipe_q[i]  <= vld_pipe_q[i-1] && !abort_i;
                addr_pipe_q[i] <= addr_pipe_q[i-1];
            end
        end
    end

endmodule
